xbar_scheduler: RTL and testbench

Round-robin, packet-aware output scheduler for the N×N crossbar datapath. Each input presents a valid/destination/last request. Each output port independently grants one input per cycle. The block drives the crossbar's enable matrix and the per-input FIFO pops. Grants are locked for the full length of a multi-beat packet and held stable under output backpressure.

---
 rtl/xbar_pkg.sv | 19 +
 rtl/xbar_scheduler_if.sv | 27 ++
 rtl/rr_pick.sv | 36 +++
 rtl/xbar_scheduler.sv | 133 +++++++++++++
 tb/tb_xbar_scheduler.sv | 139 +++++++++++++
 5 files changed

// File: rtl/xbar_pkg.sv
// Shared sizing, route type and per-output FSM encoding for the crossbar scheduler.
package xbar_pkg;

   localparam int N_SIZE     = 4;
   localparam int ROUTE_BITS = $clog2(N_SIZE);

   typedef logic [ROUTE_BITS-1:0] route_t;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } xbar_sched_state_t;

   // Round-robin successor of an input index, wrapping N_SIZE-1 back to 0.
   function automatic route_t next_route(input route_t cur);
      return (cur == route_t'(N_SIZE - 1)) ? '0 : route_t'(cur + 1'b1);
   endfunction

endpackage

// File: rtl/xbar_scheduler_if.sv
// Request/grant bundle between the input FIFOs, the scheduler and the crossbar datapath.
interface xbar_scheduler_if;
   import xbar_pkg::*;

   logic   [N_SIZE-1:0]             req_valid;
   route_t [N_SIZE-1:0]             req_dest;
   logic   [N_SIZE-1:0]             req_last;
   logic   [N_SIZE-1:0]             out_ready;

   logic   [N_SIZE-1:0][N_SIZE-1:0] enable_bus;
   logic   [N_SIZE-1:0]             pop_bus;
   logic   [N_SIZE-1:0]             out_valid;
   logic   [N_SIZE-1:0]             locked;
   logic                            stall;

   // master: requesters and output sinks; slave: the scheduler.
   modport master (
      output req_valid, req_dest, req_last, out_ready,
      input  enable_bus, pop_bus, out_valid, locked, stall
   );

   modport slave (
      input  req_valid, req_dest, req_last, out_ready,
      output enable_bus, pop_bus, out_valid, locked, stall
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after the start index, with wrap.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          found
);

   int            pos;
   logic [IW-1:0] pos_idx;

   // NOTE: combinational blocks use blocking '=' and give every output a default
   // first; a path that skips an assignment would otherwise infer a latch.
   always_comb begin
      grant   = '0;
      idx     = '0;
      found   = 1'b0;
      pos     = 0;
      pos_idx = '0;
      for (int k = 0; k < N; k++) begin
         pos = int'(start) + k;
         if (pos >= N) pos = pos - N;
         pos_idx = IW'(pos);
         if (!found && req[pos_idx]) begin
            grant[pos_idx] = 1'b1;
            idx            = pos_idx;
            found          = 1'b1;
         end
      end
   end

endmodule

// File: rtl/xbar_scheduler.sv
// Packet-aware round-robin scheduler: one IDLE/LOCKED arbiter per crossbar output,
// driving the enable matrix, per-input FIFO pops and the stall flag.
module xbar_scheduler
   import xbar_pkg::*;
(
   input logic             CLK,
   input logic             RST,
   xbar_scheduler_if.slave bus
);

   // cand[j][i]: input i has a beat headed for output j.
   logic [N_SIZE-1:0] cand [N_SIZE];

   logic [N_SIZE-1:0] rr_oh    [N_SIZE];
   route_t            rr_idx   [N_SIZE];
   logic [N_SIZE-1:0] rr_found;

   xbar_sched_state_t state_q [N_SIZE];
   xbar_sched_state_t state_d [N_SIZE];
   route_t            ptr_q   [N_SIZE];
   route_t            ptr_d   [N_SIZE];
   route_t            owner_q [N_SIZE];
   route_t            owner_d [N_SIZE];

   logic [N_SIZE-1:0] win_oh  [N_SIZE];
   route_t            win_idx [N_SIZE];
   logic [N_SIZE-1:0] win_any;
   logic [N_SIZE-1:0] xfer;

   logic [N_SIZE-1:0][N_SIZE-1:0] enable;
   logic [N_SIZE-1:0]             pop;

   always_comb begin
      for (int j = 0; j < N_SIZE; j++) begin
         cand[j] = '0;
         for (int i = 0; i < N_SIZE; i++) begin
            cand[j][i] = bus.req_valid[i] && (bus.req_dest[i] == route_t'(j));
         end
      end
   end

   for (genvar j = 0; j < N_SIZE; j++) begin : g_pick
      rr_pick #(
         .N  (N_SIZE),
         .IW (ROUTE_BITS)
      ) u_rr_pick (
         .req   (cand[j]),
         .start (ptr_q[j]),
         .grant (rr_oh[j]),
         .idx   (rr_idx[j]),
         .found (rr_found[j])
      );
   end

   // State register.
   // NOTE: sequential state uses non-blocking '<=' so every register samples
   // pre-edge values. Only the small control registers are reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int j = 0; j < N_SIZE; j++) begin
            state_q[j] <= IDLE;
            ptr_q[j]   <= '0;
            owner_q[j] <= '0;
         end
      end else begin
         for (int j = 0; j < N_SIZE; j++) begin
            state_q[j] <= state_d[j];
            ptr_q[j]   <= ptr_d[j];
            owner_q[j] <= owner_d[j];
         end
      end
   end

   // Next-state: a last-beat transfer releases the output and advances the
   // pointer past the winner; any other grant (re)locks onto the winner.
   always_comb begin
      for (int j = 0; j < N_SIZE; j++) begin
         state_d[j] = state_q[j];
         ptr_d[j]   = ptr_q[j];
         owner_d[j] = owner_q[j];
         if (xfer[j] && bus.req_last[win_idx[j]]) begin
            state_d[j] = IDLE;
            ptr_d[j]   = next_route(win_idx[j]);
         end else if (win_any[j]) begin
            state_d[j] = LOCKED;
            owner_d[j] = win_idx[j];
         end
      end
   end

   // Output: winner per output. A locked output only ever serves its owner,
   // which keeps the grant stable under backpressure and across packet beats.
   always_comb begin
      for (int j = 0; j < N_SIZE; j++) begin
         win_oh[j]  = '0;
         win_idx[j] = owner_q[j];
         win_any[j] = 1'b0;
         if (state_q[j] == LOCKED) begin
            win_any[j]             = cand[j][owner_q[j]];
            win_oh[j][owner_q[j]]  = cand[j][owner_q[j]];
         end else begin
            win_oh[j]  = rr_oh[j];
            win_idx[j] = rr_idx[j];
            win_any[j] = rr_found[j];
         end
         xfer[j] = win_any[j] & bus.out_ready[j];
      end
   end

   // Crossbar enable matrix is the transpose of the per-output one-hot grants;
   // each input has one destination, so its pop comes from at most one output.
   always_comb begin
      enable = '0;
      pop    = '0;
      for (int j = 0; j < N_SIZE; j++) begin
         for (int i = 0; i < N_SIZE; i++) begin
            enable[i][j] = win_oh[j][i];
            pop[i]       = pop[i] | (win_oh[j][i] & bus.out_ready[j]);
         end
      end
   end

   always_comb begin
      bus.enable_bus = enable;
      bus.pop_bus    = pop;
      bus.out_valid  = win_any;
      bus.stall      = |(bus.req_valid & ~pop);
      for (int j = 0; j < N_SIZE; j++) begin
         bus.locked[j] = (state_q[j] == LOCKED);
      end
   end

endmodule

// File: tb/tb_xbar_scheduler.sv
// Directed scoreboard bench for xbar_scheduler (N_SIZE = 4).
module tb_xbar_scheduler;
   import xbar_pkg::*;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   always #5 CLK = ~CLK;

   xbar_scheduler_if bus ();

   xbar_scheduler dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   typedef struct {
      string       tag;
      logic [15:0] en;
      logic [3:0]  pop;
      logic [3:0]  ov;
      logic        stall;
      logic [3:0]  lk;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // One enable_bus bit: input i driving output j sits at bit i*4+j.
   function automatic logic [15:0] en1(input int i, input int j);
      logic [15:0] one;
      one = 16'd1;
      return one << (i * 4 + j);
   endfunction

   function automatic logic [3:0] col_or(input logic [15:0] en);
      logic [3:0] r;
      r = '0;
      for (int j = 0; j < 4; j++)
         for (int i = 0; i < 4; i++)
            r[j] = r[j] | en[i * 4 + j];
      return r;
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of stimulus after the falling edge, queue its expectation,
   // then compare well before the next rising edge.
   task automatic step(input string tag, input logic rst, input logic [3:0] v,
                       input logic [7:0] d, input logic [3:0] l, input logic [3:0] r,
                       input logic [15:0] en, input logic [3:0] pop, input logic st,
                       input logic [3:0] lk);
      exp_t e;
      exp_t got;
      @(negedge CLK);
      RST           = rst;
      bus.req_valid = v;
      bus.req_dest  = d;
      bus.req_last  = l;
      bus.out_ready = r;
      e.tag   = tag;
      e.en    = en;
      e.pop   = pop;
      e.ov    = col_or(en);
      e.stall = st;
      e.lk    = lk;
      sb.push_back(e);
      #2;
      got = sb.pop_front();
      check({got.tag, ".enable"}, bus.enable_bus, got.en);
      check({got.tag, ".pop"}, {12'd0, bus.pop_bus}, {12'd0, got.pop});
      check({got.tag, ".out_valid"}, {12'd0, bus.out_valid}, {12'd0, got.ov});
      check({got.tag, ".stall"}, {15'd0, bus.stall}, {15'd0, got.stall});
      check({got.tag, ".locked"}, {12'd0, bus.locked}, {12'd0, got.lk});
   endtask

   initial begin
      bus.req_valid = '0;
      bus.req_dest  = '0;
      bus.req_last  = '0;
      bus.out_ready = '0;
      RST           = 1'b1;

      // Reset for two cycles, then idle.
      step("rst0", 1'b1, 4'h0, 8'h00, 4'h0, 4'h0, 16'h0, 4'h0, 1'b0, 4'h0);
      step("rst1", 1'b1, 4'h0, 8'h00, 4'h0, 4'h0, 16'h0, 4'h0, 1'b0, 4'h0);
      step("idle", 1'b0, 4'h0, 8'h00, 4'h0, 4'hF, 16'h0, 4'h0, 1'b0, 4'h0);

      // Round-robin: all inputs send single beats to output 2.
      step("rr0", 1'b0, 4'hF, 8'hAA, 4'hF, 4'hF, en1(0, 2), 4'b0001, 1'b1, 4'h0);
      step("rr1", 1'b0, 4'hF, 8'hAA, 4'hF, 4'hF, en1(1, 2), 4'b0010, 1'b1, 4'h0);
      step("rr2", 1'b0, 4'hF, 8'hAA, 4'hF, 4'hF, en1(2, 2), 4'b0100, 1'b1, 4'h0);
      step("rr3", 1'b0, 4'hF, 8'hAA, 4'hF, 4'hF, en1(3, 2), 4'b1000, 1'b1, 4'h0);
      step("rr4", 1'b0, 4'hF, 8'hAA, 4'hF, 4'hF, en1(0, 2), 4'b0001, 1'b1, 4'h0);

      // Packet lock on output 0: first move ptr[0] to 1, then input 1 sends 3 beats.
      step("lk_pre", 1'b0, 4'b0001, 8'h00, 4'b0001, 4'hF, en1(0, 0), 4'b0001, 1'b0, 4'h0);
      step("lk_b1",  1'b0, 4'b0011, 8'h00, 4'b0001, 4'hF, en1(1, 0), 4'b0010, 1'b1, 4'h0);
      step("lk_b2",  1'b0, 4'b0011, 8'h00, 4'b0001, 4'hF, en1(1, 0), 4'b0010, 1'b1, 4'b0001);
      step("lk_b3",  1'b0, 4'b0011, 8'h00, 4'b0011, 4'hF, en1(1, 0), 4'b0010, 1'b1, 4'b0001);
      step("lk_in0", 1'b0, 4'b0001, 8'h00, 4'b0001, 4'hF, en1(0, 0), 4'b0001, 1'b0, 4'h0);

      // Backpressure on output 1: input 2 holds the grant while input 0 waits.
      step("bp1",   1'b0, 4'b0100, 8'h10, 4'b0100, 4'b1101, en1(2, 1), 4'h0, 1'b1, 4'h0);
      step("bp2",   1'b0, 4'b0101, 8'h11, 4'b0101, 4'b1101, en1(2, 1), 4'h0, 1'b1, 4'b0010);
      step("bp3",   1'b0, 4'b0101, 8'h11, 4'b0101, 4'b1101, en1(2, 1), 4'h0, 1'b1, 4'b0010);
      step("bp4",   1'b0, 4'b0101, 8'h11, 4'b0101, 4'b1101, en1(2, 1), 4'h0, 1'b1, 4'b0010);
      step("bp_go", 1'b0, 4'b0101, 8'h11, 4'b0101, 4'hF, en1(2, 1), 4'b0100, 1'b1, 4'b0010);
      // ptr[1] is now 3: input 3 beats input 0.
      step("bp_ptr3", 1'b0, 4'b1001, 8'h55, 4'b1001, 4'hF, en1(3, 1), 4'b1000, 1'b1, 4'h0);
      // Winner 3 wraps ptr[1] to 0.
      step("bp_wrap", 1'b0, 4'b0001, 8'h55, 4'b0001, 4'hF, en1(0, 1), 4'b0001, 1'b0, 4'h0);

      // Parallel: two permutations, every input transfers in one cycle.
      step("par_id",  1'b0, 4'hF, 8'hE4, 4'hF, 4'hF,
           en1(0, 0) | en1(1, 1) | en1(2, 2) | en1(3, 3), 4'hF, 1'b0, 4'h0);
      step("par_rev", 1'b0, 4'hF, 8'h1B, 4'hF, 4'hF,
           en1(0, 3) | en1(1, 2) | en1(2, 1) | en1(3, 0), 4'hF, 1'b0, 4'h0);

      // Reset mid-packet on output 3 (ptr[3] is 1 here).
      step("mr_b1",    1'b0, 4'b0100, 8'hFF, 4'b0000, 4'hF, en1(2, 3), 4'b0100, 1'b0, 4'h0);
      step("mr_rst",   1'b1, 4'b0000, 8'hFF, 4'b0000, 4'hF, 16'h0, 4'h0, 1'b0, 4'b1000);
      step("mr_after", 1'b0, 4'b0101, 8'hFF, 4'b0000, 4'hF, en1(0, 3), 4'b0001, 1'b1, 4'h0);
      step("mr_lock",  1'b0, 4'b0101, 8'hFF, 4'b0001, 4'hF, en1(0, 3), 4'b0001, 1'b1, 4'b1000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
